// File: rtl/eth_tx_fcs_append.sv
// Ethernet transmit tail stage: passes the upstream preamble/SFD/frame stream
// to the PHY with one cycle of latency, zero-pads short frames, appends the
// CRC-32 FCS (low byte first) and holds o_tx_en low for the inter-frame gap.
module eth_tx_fcs_append #(
    parameter int MIN_LEN    = 60,
    parameter int IFG_CYCLES = 12
) (
    input  logic        i_tx_clk,
    input  logic        rst_n,
    input  logic        i_tx_en,
    input  logic [7:0]  i_tx_data,
    output logic        o_ready,
    output logic        o_tx_en,
    output logic [7:0]  o_tx_data,
    output logic [31:0] o_crc32,
    output logic        o_frame_done,
    output logic        o_err
);

    localparam logic [31:0] CRC_POLY   = 32'hEDB88320;
    localparam logic [31:0] CRC_PRESET = 32'hFFFFFFFF;
    localparam logic [10:0] MIN_C      = MIN_LEN[10:0];
    localparam logic [15:0] IFG_C      = IFG_CYCLES[15:0];
    localparam logic [10:0] CNT_MAX    = 11'h7FF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DATA     = 3'd2,
        ST_PAD      = 3'd3,
        ST_FCS      = 3'd4,
        ST_IFG      = 3'd5
    } state_t;

    // Reflected CRC-32 update of one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if ((c[0] ^ data[i]) == 1'b1) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_ready;
    logic        r_tx_en;
    logic [7:0]  r_tx_data;
    logic [31:0] r_crc32;
    logic        r_frame_done;
    logic        r_err;
    logic [31:0] r_crc;
    logic [10:0] r_cnt;
    logic [2:0]  r_pre_cnt;
    logic [1:0]  r_fcs_idx;
    logic [15:0] r_ifg_cnt;

    logic        w_ready_nxt;
    logic        w_tx_en_nxt;
    logic [7:0]  w_tx_data_nxt;
    logic [31:0] w_crc32_nxt;
    logic        w_frame_done_nxt;
    logic        w_err_nxt;
    logic [31:0] w_crc_nxt;
    logic [10:0] w_cnt_nxt;
    logic [2:0]  w_pre_cnt_nxt;
    logic [1:0]  w_fcs_idx_nxt;
    logic [15:0] w_ifg_cnt_nxt;

    logic [31:0] w_crc_data;
    logic [31:0] w_crc_pad;
    logic [31:0] w_fcs_first;
    logic [10:0] w_cnt_inc;
    logic [11:0] w_cnt_diff;
    logic        w_need_pad;
    logic        w_abort;
    logic        w_intrude;
    logic [7:0]  w_fcs_byte;

    assign w_crc_data  = crc32_byte(r_crc, i_tx_data);
    assign w_crc_pad   = crc32_byte(r_crc, 8'h00);
    assign w_fcs_first = ~r_crc;
    assign w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + 11'd1);
    // Borrow out of (count - MIN_LEN) means the frame is still short.
    assign w_cnt_diff  = {1'b0, r_cnt} - {1'b0, MIN_C};
    assign w_need_pad  = w_cnt_diff[11];

    // Upstream dropped tx_en inside the 8-byte preamble/SFD.
    assign w_abort   = (r_state == ST_PREAMBLE) && !i_tx_en;
    // Upstream raised tx_en while we are busy outside the pass-through phase.
    assign w_intrude = i_tx_en && !r_ready &&
                       (r_state != ST_PREAMBLE) && (r_state != ST_DATA);
    assign w_err_nxt = w_abort || w_intrude;

    // Select the FCS byte for the 2nd..4th FCS cycles from the latched FCS.
    always_comb begin
        case (r_fcs_idx)
            2'd1:    w_fcs_byte = r_crc32[15:8];
            2'd2:    w_fcs_byte = r_crc32[23:16];
            2'd3:    w_fcs_byte = r_crc32[31:24];
            default: w_fcs_byte = r_crc32[7:0];
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_tx_en) w_state_nxt = ST_PREAMBLE;
                else         w_state_nxt = ST_IDLE;
            end
            ST_PREAMBLE: begin
                if (!i_tx_en)                w_state_nxt = ST_IFG;
                else if (r_pre_cnt == 3'd7)  w_state_nxt = ST_DATA;
                else                         w_state_nxt = ST_PREAMBLE;
            end
            ST_DATA: begin
                if (i_tx_en)         w_state_nxt = ST_DATA;
                else if (w_need_pad) w_state_nxt = ST_PAD;
                else                 w_state_nxt = ST_FCS;
            end
            ST_PAD: begin
                if (w_need_pad) w_state_nxt = ST_PAD;
                else            w_state_nxt = ST_FCS;
            end
            ST_FCS: begin
                if (r_fcs_idx == 2'd3) w_state_nxt = ST_IFG;
                else                   w_state_nxt = ST_FCS;
            end
            ST_IFG: begin
                if (r_ifg_cnt == IFG_C) w_state_nxt = ST_IDLE;
                else                    w_state_nxt = ST_IFG;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered PHY outputs and datapath.
    always_comb begin
        w_ready_nxt      = 1'b0;
        w_tx_en_nxt      = 1'b0;
        w_tx_data_nxt    = 8'h00;
        w_crc32_nxt      = r_crc32;
        w_frame_done_nxt = 1'b0;
        w_crc_nxt        = r_crc;
        w_cnt_nxt        = r_cnt;
        w_pre_cnt_nxt    = r_pre_cnt;
        w_fcs_idx_nxt    = r_fcs_idx;
        w_ifg_cnt_nxt    = r_ifg_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_tx_en) begin
                    w_tx_en_nxt   = 1'b1;
                    w_tx_data_nxt = i_tx_data;
                    w_cnt_nxt     = 11'd0;
                    w_pre_cnt_nxt = 3'd1;
                    w_crc_nxt     = CRC_PRESET;
                end else begin
                    w_ready_nxt   = 1'b1;
                end
            end
            ST_PREAMBLE: begin
                if (i_tx_en) begin
                    w_tx_en_nxt   = 1'b1;
                    w_tx_data_nxt = i_tx_data;
                    w_pre_cnt_nxt = r_pre_cnt + 3'd1;
                end else begin
                    w_ifg_cnt_nxt = 16'd0;
                end
            end
            ST_DATA, ST_PAD: begin
                w_tx_en_nxt = 1'b1;
                if ((r_state == ST_DATA) && i_tx_en) begin
                    w_tx_data_nxt = i_tx_data;
                    w_crc_nxt     = w_crc_data;
                    w_cnt_nxt     = w_cnt_inc;
                end else if (w_need_pad) begin
                    w_tx_data_nxt = 8'h00;
                    w_crc_nxt     = w_crc_pad;
                    w_cnt_nxt     = w_cnt_inc;
                end else begin
                    // First FCS byte leaves directly from the live CRC.
                    w_tx_data_nxt = w_fcs_first[7:0];
                    w_crc32_nxt   = w_fcs_first;
                    w_fcs_idx_nxt = 2'd1;
                end
            end
            ST_FCS: begin
                w_tx_en_nxt   = 1'b1;
                w_tx_data_nxt = w_fcs_byte;
                w_fcs_idx_nxt = r_fcs_idx + 2'd1;
                if (r_fcs_idx == 2'd3) begin
                    w_frame_done_nxt = 1'b1;
                    w_ifg_cnt_nxt    = 16'd0;
                end else begin
                    w_frame_done_nxt = 1'b0;
                end
            end
            ST_IFG: begin
                if (r_ifg_cnt == IFG_C) begin
                    w_ready_nxt = 1'b1;
                end else begin
                    w_ifg_cnt_nxt = r_ifg_cnt + 16'd1;
                end
            end
            default: begin
                w_ready_nxt = 1'b1;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge i_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready      <= 1'b1;
            r_tx_en      <= 1'b0;
            r_tx_data    <= 8'h00;
            r_crc32      <= 32'h0000_0000;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
            r_crc        <= CRC_PRESET;
            r_cnt        <= 11'd0;
            r_pre_cnt    <= 3'd0;
            r_fcs_idx    <= 2'd0;
            r_ifg_cnt    <= 16'd0;
        end else begin
            r_ready      <= w_ready_nxt;
            r_tx_en      <= w_tx_en_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_crc32      <= w_crc32_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_err        <= w_err_nxt;
            r_crc        <= w_crc_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pre_cnt    <= w_pre_cnt_nxt;
            r_fcs_idx    <= w_fcs_idx_nxt;
            r_ifg_cnt    <= w_ifg_cnt_nxt;
        end
    end

    assign o_ready      = r_ready;
    assign o_tx_en      = r_tx_en;
    assign o_tx_data    = r_tx_data;
    assign o_crc32      = r_crc32;
    assign o_frame_done = r_frame_done;
    assign o_err        = r_err;

endmodule

// File: tb/tb_eth_tx_fcs_append.sv
// Directed bench for eth_tx_fcs_append: one instance with MIN_LEN=0 for the
// CRC check-value frame, one with default parameters for padding, long frame,
// back-to-back, abort and mid-frame reset cases.
module tb_eth_tx_fcs_append;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tb_en;
    logic [7:0]  tb_data;
    logic        sel;

    logic        w_en0, w_en1;
    logic        w0_ready, w0_tx_en, w0_done, w0_err;
    logic [7:0]  w0_tx_data;
    logic [31:0] w0_crc32;
    logic        w1_ready, w1_tx_en, w1_done, w1_err;
    logic [7:0]  w1_tx_data;
    logic [31:0] w1_crc32;

    logic        m_ready, m_tx_en, m_done, m_err;
    logic [7:0]  m_tx_data;
    logic [31:0] m_crc32;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  pay_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  cap[$];
    logic [31:0] exp_fcs;

    int cyc, run_len, last_run, low_len, last_low, err_cnt, done_cnt;
    int done_pos, t_done, t_ready_rise, ready_bad;
    logic [7:0] done_byte;
    logic prev_en, prev_ready;

    // Free-running byte clock.
    always #5 clk = ~clk;

    assign w_en0 = tb_en & sel;
    assign w_en1 = tb_en & ~sel;

    assign m_ready   = sel ? w0_ready   : w1_ready;
    assign m_tx_en   = sel ? w0_tx_en   : w1_tx_en;
    assign m_tx_data = sel ? w0_tx_data : w1_tx_data;
    assign m_crc32   = sel ? w0_crc32   : w1_crc32;
    assign m_done    = sel ? w0_done    : w1_done;
    assign m_err     = sel ? w0_err     : w1_err;

    eth_tx_fcs_append #(.MIN_LEN(0), .IFG_CYCLES(12)) u_dut_min0 (
        .i_tx_clk(clk), .rst_n(rst_n), .i_tx_en(w_en0), .i_tx_data(tb_data),
        .o_ready(w0_ready), .o_tx_en(w0_tx_en), .o_tx_data(w0_tx_data),
        .o_crc32(w0_crc32), .o_frame_done(w0_done), .o_err(w0_err)
    );

    eth_tx_fcs_append u_dut (
        .i_tx_clk(clk), .rst_n(rst_n), .i_tx_en(w_en1), .i_tx_data(tb_data),
        .o_ready(w1_ready), .o_tx_en(w1_tx_en), .o_tx_data(w1_tx_data),
        .o_crc32(w1_crc32), .o_frame_done(w1_done), .o_err(w1_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    initial begin
        cyc = 0; run_len = 0; last_run = 0; low_len = 0; last_low = 0;
        err_cnt = 0; done_cnt = 0; done_pos = 0; t_done = 0; t_ready_rise = 0;
        ready_bad = 0; done_byte = 8'h00; prev_en = 1'b0; prev_ready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (m_tx_en === 1'b1) begin
                cap.push_back(m_tx_data);
                run_len++;
                if (!prev_en) last_low = low_len;
                low_len = 0;
            end else begin
                if (prev_en) last_run = run_len;
                run_len = 0;
                low_len++;
            end
            if (m_tx_en === 1'b1 && m_ready === 1'b1) ready_bad++;
            if (m_err === 1'b1) err_cnt++;
            if (m_done === 1'b1) begin
                done_cnt++;
                done_byte = m_tx_data;
                done_pos  = cap.size();
                t_done    = cyc;
            end
            if (m_ready === 1'b1 && !prev_ready) t_ready_rise = cyc;
            prev_en    = (m_tx_en === 1'b1);
            prev_ready = (m_ready === 1'b1);
        end
    end

    task automatic clr_mon();
        cap.delete();
        run_len = 0; last_run = 0; low_len = 0; last_low = 0;
        err_cnt = 0; done_cnt = 0; done_pos = 0; t_done = 0; t_ready_rise = 0;
        ready_bad = 0; done_byte = 8'h00;
        prev_en = (m_tx_en === 1'b1); prev_ready = (m_ready === 1'b1);
    endtask

    // Build the upstream stream and the expected PHY stream from pay_q.
    task automatic build_exp(input int min_len);
        logic [31:0] c;
        logic [7:0]  b;
        int nb;
        tx_q.delete(); exp_q.delete();
        for (int i = 0; i < 7; i++) begin tx_q.push_back(8'h55); exp_q.push_back(8'h55); end
        tx_q.push_back(8'hD5); exp_q.push_back(8'hD5);
        nb = (pay_q.size() > min_len) ? pay_q.size() : min_len;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < nb; i++) begin
            b = (i < pay_q.size()) ? pay_q[i] : 8'h00;
            if (i < pay_q.size()) tx_q.push_back(b);
            exp_q.push_back(b);
            c = c ^ {24'h0, b};
            for (int k = 0; k < 8; k++) c = (c >> 1) ^ (32'hEDB88320 & {32{c[0]}});
        end
        exp_fcs = ~c;
        exp_q.push_back(exp_fcs[7:0]);   exp_q.push_back(exp_fcs[15:8]);
        exp_q.push_back(exp_fcs[23:16]); exp_q.push_back(exp_fcs[31:24]);
    endtask

    function automatic int stream_mism();
        int m;
        int n;
        m = (cap.size() != exp_q.size()) ? 1 : 0;
        n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (cap[i] !== exp_q[i]) m++;
        return m;
    endfunction

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (m_ready === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic send_frame(input int nb);
        bit ok;
        wait_ready(200, ok);
        check_eq("send_ready", 32'(ok), 32'd1);
        for (int i = 0; i < nb; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            tb_en = 1'b1; tb_data = tx_q[i];
        end
        @(posedge clk); #1;
        tb_en = 1'b0; tb_data = 8'h00;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int c;
        c = 0;
        while (done_cnt < target && c < budget) begin @(posedge clk); #1; c++; end
        check_eq(tag, 32'(done_cnt), 32'(target));
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        int zc, n;
        rst_n = 1'b0; tb_en = 1'b0; tb_data = 8'h00; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready",  32'(w1_ready), 32'd1);
        check_eq("rst_tx_en",  32'(w1_tx_en), 32'd0);
        check_eq("rst_data",   {24'h0, w1_tx_data}, 32'h0);
        check_eq("rst_crc32",  w1_crc32, 32'h0);
        check_eq("rst_done",   32'(w1_done), 32'd0);
        check_eq("rst_err",    32'(w1_err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("post_rst_ready0", 32'(w0_ready), 32'd1);

        // Check value frame "123456789" with no padding.
        sel = 1'b1;
        @(posedge clk); #1;
        clr_mon();
        pay_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        build_exp(0);
        send_frame(tx_q.size());
        wait_done(1, 100, "t1_done");
        repeat (3) @(posedge clk);
        #1;
        check_eq("t1_stream",   32'(stream_mism()), 32'd0);
        check_eq("t1_len",      32'(cap.size()), 32'd21);
        check_eq("t1_fcs0",     {24'h0, cap[17]}, 32'h26);
        check_eq("t1_fcs1",     {24'h0, cap[18]}, 32'h39);
        check_eq("t1_fcs2",     {24'h0, cap[19]}, 32'hF4);
        check_eq("t1_fcs3",     {24'h0, cap[20]}, 32'hCB);
        check_eq("t1_crc32",    m_crc32, 32'hCBF43926);
        check_eq("t1_run",      32'(last_run), 32'd21);
        check_eq("t1_done_b",   {24'h0, done_byte}, 32'hCB);
        check_eq("t1_done_pos", 32'(done_pos), 32'd21);
        check_eq("t1_err",      32'(err_cnt), 32'd0);

        // Short frame padded to 60 bytes.
        sel = 1'b0;
        @(posedge clk); #1;
        clr_mon();
        pay_q.delete();
        for (int i = 0; i < 15; i++) pay_q.push_back(8'(i * 37 + 1));
        build_exp(60);
        send_frame(tx_q.size());
        wait_done(1, 200, "t2_done");
        repeat (3) @(posedge clk);
        #1;
        zc = 0;
        for (int i = 23; i < 68; i++) if (cap[i] === 8'h00) zc++;
        check_eq("t2_stream", 32'(stream_mism()), 32'd0);
        check_eq("t2_pad0",   32'(zc), 32'd45);
        check_eq("t2_run",    32'(last_run), 32'd72);
        check_eq("t2_crc32",  m_crc32, exp_fcs);

        // Full-size frame, no padding.
        clr_mon();
        pay_q.delete();
        for (int i = 0; i < 1514; i++) pay_q.push_back(8'(i) ^ 8'hA5);
        build_exp(60);
        send_frame(tx_q.size());
        wait_done(1, 2000, "t3_done");
        repeat (16) @(posedge clk);
        #1;
        check_eq("t3_stream",  32'(stream_mism()), 32'd0);
        check_eq("t3_run",     32'(last_run), 32'd1526);
        check_eq("t3_crc32",   m_crc32, exp_fcs);
        check_eq("t3_rdy_bad", 32'(ready_bad), 32'd0);
        check_eq("t3_rdy_gap", 32'(t_ready_rise - t_done), 32'd13);

        // Back-to-back frames, then an intrusion during the gap.
        clr_mon();
        pay_q.delete();
        for (int i = 0; i < 20; i++) pay_q.push_back(8'(i + 100));
        build_exp(60);
        n = exp_q.size();
        for (int i = 0; i < n; i++) exp_q.push_back(exp_q[i]);
        send_frame(tx_q.size());
        send_frame(tx_q.size());
        wait_done(2, 400, "t4_done");
        check_eq("t4_gap",    32'(last_low), 32'd13);
        repeat (3) @(posedge clk);
        #1;
        tb_en = 1'b1; tb_data = 8'h55;
        @(posedge clk); #1;
        tb_en = 1'b0; tb_data = 8'h00;
        wait_ready(50, ok);
        repeat (2) @(posedge clk);
        #1;
        check_eq("t4_stream", 32'(stream_mism()), 32'd0);
        check_eq("t4_len",    32'(cap.size()), 32'd144);
        check_eq("t4_err",    32'(err_cnt), 32'd1);
        check_eq("t4_ready",  32'(ok), 32'd1);

        // Abort after 5 preamble bytes.
        clr_mon();
        pay_q = '{8'h01, 8'h02};
        build_exp(60);
        send_frame(5);
        repeat (20) @(posedge clk);
        #1;
        zc = 0;
        foreach (cap[i]) if (cap[i] === 8'h55) zc++;
        check_eq("t5_len",   32'(cap.size()), 32'd5);
        check_eq("t5_55s",   32'(zc), 32'd5);
        check_eq("t5_run",   32'(last_run), 32'd5);
        check_eq("t5_err",   32'(err_cnt), 32'd1);
        check_eq("t5_done",  32'(done_cnt), 32'd0);
        wait_ready(50, ok);
        check_eq("t5_ready", 32'(ok), 32'd1);

        // Reset in the middle of DATA, then a clean frame.
        pay_q.delete();
        for (int i = 0; i < 30; i++) pay_q.push_back(8'(i + 7));
        build_exp(60);
        wait_ready(50, ok);
        for (int i = 0; i < 15; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            tb_en = 1'b1; tb_data = tx_q[i];
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("t6_tx_en", 32'(m_tx_en), 32'd0);
        check_eq("t6_ready", 32'(m_ready), 32'd1);
        check_eq("t6_crc32", m_crc32, 32'h0);
        tb_en = 1'b0; tb_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clr_mon();
        pay_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        build_exp(60);
        send_frame(tx_q.size());
        wait_done(1, 200, "t6_done");
        repeat (3) @(posedge clk);
        #1;
        check_eq("t6_stream",  32'(stream_mism()), 32'd0);
        check_eq("t6_crc_new", m_crc32, exp_fcs);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
